// File: rtl/csb_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the CSB arbiter.
package csb_arb_pkg;

    localparam int unsigned CSB_ADDR_W = 16;
    localparam int unsigned CSB_DATA_W = 32;

    // rr_pick works on a fixed 8-wide vector; callers zero-extend to this width.
    localparam int unsigned RR_MAX   = 8;
    localparam int unsigned RR_IDX_W = 3;

    typedef struct packed {
        logic [CSB_ADDR_W-1:0] addr;
        logic [CSB_DATA_W-1:0] wdat;
        logic                  write;
        logic                  nposted;
    } csb_req_t;

    typedef enum logic {
        StIdle,
        StIssue
    } arb_state_e;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0] at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int unsigned         n);
        rr_pick_t            res;
        int unsigned         j;
        logic [RR_IDX_W-1:0] jj;
        res = '0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            j = 32'(ptr) + k;
            if (j >= n) begin
                j = j - n;
            end
            jj = j[RR_IDX_W-1:0];
            if ((k < n) && !res.found && valid[jj]) begin
                res.found = 1'b1;
                res.idx   = jj;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/csb_arb_id_fifo.sv
// In-order FIFO of requester indices for outstanding CSB transactions.
module csb_arb_id_fifo
    import csb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_id_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal together with a pop, which frees the head slot.
    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    // Storage and pointer/count update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_id_i;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/csb_arbiter.sv
// Round-robin arbiter sharing one NVDLA CSB master port between NREQ requesters,
// with in-order routing of read data and write completions back to their issuers.
module csb_arbiter
    import csb_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned MAX_RD = 4,
    parameter int unsigned MAX_WR = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*CSB_ADDR_W-1:0] req_addr_i,
    input  logic [NREQ*CSB_DATA_W-1:0] req_wdat_i,
    input  logic [NREQ-1:0]            req_write_i,
    input  logic [NREQ-1:0]            req_nposted_i,
    output logic [NREQ-1:0]            rsp_r_valid_o,
    output logic [NREQ-1:0]            rsp_wr_complete_o,
    output logic [CSB_DATA_W-1:0]      rsp_r_data_o,
    output logic                       csb_valid_o,
    output logic [CSB_ADDR_W-1:0]      csb_addr_o,
    output logic [CSB_DATA_W-1:0]      csb_wdat_o,
    output logic                       csb_write_o,
    output logic                       csb_nposted_o,
    input  logic                       csb_ready_i,
    input  logic                       csb_r_valid_i,
    input  logic [CSB_DATA_W-1:0]      csb_r_data_i,
    input  logic                       csb_wr_complete_i,
    output logic                       err_o
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e       r_state;
    csb_req_t         r_req;
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_err;

    logic             w_rd_full;
    logic             w_rd_empty;
    logic [IDX_W-1:0] w_rd_head;
    logic             w_wr_full;
    logic             w_wr_empty;
    logic [IDX_W-1:0] w_wr_head;
    logic             w_rd_pop;
    logic             w_wr_pop;
    logic             w_rd_push;
    logic             w_wr_push;

    logic [NREQ-1:0]     w_elig;
    logic [RR_MAX-1:0]   w_elig_ext;
    logic [RR_IDX_W-1:0] w_ptr_ext;
    rr_pick_t            w_pick;
    logic                w_can_grant;
    logic                w_grant;
    logic [IDX_W-1:0]    w_win;
    csb_req_t            w_req_win;

    // Responses only pop when an ID is actually outstanding; strays are flagged instead.
    assign w_rd_pop = csb_r_valid_i && !w_rd_empty;
    assign w_wr_pop = csb_wr_complete_i && !w_wr_empty;

    // Eligibility: a popping response frees a slot for a same-cycle push.
    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!req_write_i[i]) begin
                w_elig[i] = req_valid_i[i] && (!w_rd_full || w_rd_pop);
            end else if (req_nposted_i[i]) begin
                w_elig[i] = req_valid_i[i] && (!w_wr_full || w_wr_pop);
            end else begin
                w_elig[i] = req_valid_i[i];
            end
        end
    end

    // Round-robin selection of the winning requester.
    always_comb begin
        w_elig_ext              = '0;
        w_elig_ext[NREQ-1:0]    = w_elig;
        w_ptr_ext               = '0;
        w_ptr_ext[IDX_W-1:0]    = r_rr_ptr;
        w_pick                  = rr_pick(w_elig_ext, w_ptr_ext, NREQ);
        w_win                   = IDX_W'(w_pick.idx);
    end

    // A new grant may start from idle, or back-to-back as the current transfer is accepted.
    assign w_can_grant = (r_state == StIdle) || csb_ready_i;
    assign w_grant     = w_can_grant && w_pick.found;

    // Mux out the winning requester's request fields.
    always_comb begin
        w_req_win = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_req_win.addr    = req_addr_i[i*CSB_ADDR_W +: CSB_ADDR_W];
                w_req_win.wdat    = req_wdat_i[i*CSB_DATA_W +: CSB_DATA_W];
                w_req_win.write   = req_write_i[i];
                w_req_win.nposted = req_nposted_i[i];
            end
        end
    end

    // One-hot upstream handshake for the winner in the grant cycle.
    always_comb begin
        req_ready_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready_o[i] = w_grant && (w_win == IDX_W'(i));
        end
    end

    // Posted writes expect no completion, so they are not tracked.
    assign w_rd_push = w_grant && !w_req_win.write;
    assign w_wr_push = w_grant && w_req_win.write && w_req_win.nposted;

    csb_arb_id_fifo #(
        .DEPTH (MAX_RD),
        .WIDTH (IDX_W)
    ) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (w_rd_push),
        .push_id_i (w_win),
        .pop_i     (w_rd_pop),
        .full_o    (w_rd_full),
        .empty_o   (w_rd_empty),
        .head_o    (w_rd_head)
    );

    csb_arb_id_fifo #(
        .DEPTH (MAX_WR),
        .WIDTH (IDX_W)
    ) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (w_wr_push),
        .push_id_i (w_win),
        .pop_i     (w_wr_pop),
        .full_o    (w_wr_full),
        .empty_o   (w_wr_empty),
        .head_o    (w_wr_head)
    );

    // Route responses to the requester at the head of the matching FIFO.
    always_comb begin
        rsp_r_valid_o     = '0;
        rsp_wr_complete_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rsp_r_valid_o[i]     = w_rd_pop && (w_rd_head == IDX_W'(i));
            rsp_wr_complete_o[i] = w_wr_pop && (w_wr_head == IDX_W'(i));
        end
    end

    assign rsp_r_data_o = csb_r_data_i;

    // Issue FSM: latches the granted request and holds it until NVDLA accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_req    <= '0;
            r_rr_ptr <= '0;
        end else if (w_can_grant) begin
            if (w_pick.found) begin
                r_state  <= StIssue;
                r_req    <= w_req_win;
                r_rr_ptr <= (w_win == IDX_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
            end else begin
                r_state <= StIdle;
            end
        end
    end

    // Sticky flag for responses that arrive with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((csb_r_valid_i && w_rd_empty) || (csb_wr_complete_i && w_wr_empty)) begin
            r_err <= 1'b1;
        end
    end

    assign csb_valid_o   = (r_state == StIssue);
    assign csb_addr_o    = r_req.addr;
    assign csb_wdat_o    = r_req.wdat;
    assign csb_write_o   = r_req.write;
    assign csb_nposted_o = r_req.nposted;
    assign err_o         = r_err;

endmodule

// File: tb/tb_csb_arbiter.sv
// Self-checking bench for csb_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_csb_arbiter;
    import csb_arb_pkg::*;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned MAX_RD = 4;
    localparam int unsigned MAX_WR = 4;
    localparam int          NCYC   = 3000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdat;
    logic [NREQ-1:0]   req_write;
    logic [NREQ-1:0]   req_nposted;
    logic [NREQ-1:0]   rsp_rv;
    logic [NREQ-1:0]   rsp_wc;
    logic [31:0]       rsp_rdata;
    logic              csb_valid;
    logic [15:0]       csb_addr;
    logic [31:0]       csb_wdat;
    logic              csb_write;
    logic              csb_nposted;
    logic              csb_ready;
    logic              csb_rv;
    logic [31:0]       csb_rdata;
    logic              csb_wc;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    csb_arbiter #(
        .NREQ   (NREQ),
        .MAX_RD (MAX_RD),
        .MAX_WR (MAX_WR)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_addr_i        (req_addr),
        .req_wdat_i        (req_wdat),
        .req_write_i       (req_write),
        .req_nposted_i     (req_nposted),
        .rsp_r_valid_o     (rsp_rv),
        .rsp_wr_complete_o (rsp_wc),
        .rsp_r_data_o      (rsp_rdata),
        .csb_valid_o       (csb_valid),
        .csb_addr_o        (csb_addr),
        .csb_wdat_o        (csb_wdat),
        .csb_write_o       (csb_write),
        .csb_nposted_o     (csb_nposted),
        .csb_ready_i       (csb_ready),
        .csb_r_valid_i     (csb_rv),
        .csb_r_data_i      (csb_rdata),
        .csb_wr_complete_i (csb_wc),
        .err_o             (err)
    );

    typedef struct packed {
        logic [1:0]  rv;
        logic [1:0]  wr;
        logic [1:0]  np;
        logic [15:0] a0;
        logic [15:0] a1;
        logic        crdy;
        logic        crv;
        logic [31:0] cdata;
        logic        cwc;
        logic [1:0]  e_rdy;
        logic        e_cv;
        logic [15:0] e_addr;
        logic [1:0]  e_rrv;
        logic [1:0]  e_rwc;
        logic        e_err;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] wr, input logic [1:0] np,
                                input logic [15:0] a0, input logic [15:0] a1,
                                input logic crdy, input logic crv, input logic [31:0] cdata,
                                input logic cwc, input logic [1:0] e_rdy, input logic e_cv,
                                input logic [15:0] e_addr, input logic [1:0] e_rrv,
                                input logic [1:0] e_rwc, input logic e_err);
        vec_t v;
        v = '{rv, wr, np, a0, a1, crdy, crv, cdata, cwc, e_rdy, e_cv, e_addr, e_rrv, e_rwc, e_err};
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_addr    = '0;
        req_wdat    = '0;
        req_write   = '0;
        req_nposted = '0;
        csb_ready   = 1'b0;
        csb_rv      = 1'b0;
        csb_rdata   = '0;
        csb_wc      = 1'b0;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic np,
                           input logic [15:0] a, input logic [31:0] d);
        req_valid[i]         = v;
        req_write[i]         = w;
        req_nposted[i]       = np;
        req_addr[i*16 +: 16] = a;
        req_wdat[i*32 +: 32] = d;
    endtask

    // Leaves the bench 1ns after a rising edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model state.
    int          m_rd_q[$];
    int          m_wr_q[$];
    bit          m_busy;
    csb_req_t    m_cur;
    int          m_ptr;
    bit          m_err;
    bit          p_valid [NREQ];
    logic [15:0] p_addr  [NREQ];
    logic [31:0] p_wdat  [NREQ];
    bit          p_write [NREQ];
    bit          p_np    [NREQ];

    task automatic run_random();
        bit          rd_pop;
        bit          wr_pop;
        bit          can_grant;
        bit          elig [NREQ];
        int          win;
        int          j;
        logic [1:0]  e_rdy;
        logic [1:0]  e_rrv;
        logic [1:0]  e_rwc;
        m_rd_q.delete();
        m_wr_q.delete();
        m_busy = 0;
        m_cur  = '0;
        m_ptr  = 0;
        m_err  = 0;
        for (int i = 0; i < NREQ; i++) p_valid[i] = 0;
        for (int c = 0; c < NCYC; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!p_valid[i] && ($urandom_range(0, 99) < 50)) begin
                    p_valid[i] = 1;
                    p_addr[i]  = 16'($urandom);
                    p_wdat[i]  = $urandom;
                    p_write[i] = 1'($urandom);
                    p_np[i]    = 1'($urandom);
                end
                set_req(i, p_valid[i], p_write[i], p_np[i], p_addr[i], p_wdat[i]);
            end
            csb_ready = ($urandom_range(0, 99) < 60);
            csb_rv    = ($urandom_range(0, 99) < 25);
            csb_rdata = $urandom;
            csb_wc    = ($urandom_range(0, 99) < 20);
            @(negedge clk);
            rd_pop    = csb_rv && (m_rd_q.size() > 0);
            wr_pop    = csb_wc && (m_wr_q.size() > 0);
            can_grant = !m_busy || csb_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (!p_write[i]) elig[i] = p_valid[i] && (m_rd_q.size() < MAX_RD || rd_pop);
                else if (p_np[i]) elig[i] = p_valid[i] && (m_wr_q.size() < MAX_WR || wr_pop);
                else elig[i] = p_valid[i];
            end
            win = -1;
            if (can_grant) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (m_ptr + k) % NREQ;
                    if (win < 0 && elig[j]) win = j;
                end
            end
            e_rdy = '0;
            if (win >= 0) e_rdy[win] = 1'b1;
            e_rrv = '0;
            if (rd_pop) e_rrv[m_rd_q[0]] = 1'b1;
            e_rwc = '0;
            if (wr_pop) e_rwc[m_wr_q[0]] = 1'b1;
            check($sformatf("random cycle %0d", c),
                  {req_ready, csb_valid, csb_addr, csb_wdat, csb_write, csb_nposted,
                   rsp_rv, rsp_wc, rsp_rdata, err},
                  {e_rdy, m_busy, m_cur.addr, m_cur.wdat, m_cur.write, m_cur.nposted,
                   e_rrv, e_rwc, csb_rdata, m_err});
            if (csb_rv && !rd_pop) m_err = 1;
            if (csb_wc && !wr_pop) m_err = 1;
            if (rd_pop) void'(m_rd_q.pop_front());
            if (wr_pop) void'(m_wr_q.pop_front());
            if (win >= 0) begin
                if (!p_write[win]) m_rd_q.push_back(win);
                else if (p_np[win]) m_wr_q.push_back(win);
                m_cur        = '{p_addr[win], p_wdat[win], p_write[win], p_np[win]};
                m_busy       = 1;
                m_ptr        = (win + 1) % NREQ;
                p_valid[win] = 0;
            end else if (can_grant) begin
                m_busy = 0;
            end
            next_cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        rv    wr    np    a0       a1       rdy  crv  cdata          cwc
        //        e_rdy e_cv e_addr e_rrv e_rwc e_err
        vecs[0]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 32'h0, 0,
                      2'b00, 0, 16'h0000, 2'b00, 2'b00, 0);
        vecs[1]  = mk(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0000, 0, 0, 32'h0, 0,
                      2'b01, 0, 16'h0000, 2'b00, 2'b00, 0);
        vecs[2]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 0, 32'h0, 0,
                      2'b00, 1, 16'h0010, 2'b00, 2'b00, 0);
        vecs[3]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 32'h0, 0,
                      2'b00, 0, 16'h0010, 2'b00, 2'b00, 0);
        vecs[4]  = vecs[3];
        vecs[5]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 1, 32'hDEADBEEF, 0,
                      2'b00, 0, 16'h0010, 2'b01, 2'b00, 0);
        vecs[6]  = vecs[3];
        vecs[7]  = mk(2'b10, 2'b00, 2'b00, 16'h0000, 16'h0020, 0, 0, 32'h0, 0,
                      2'b10, 0, 16'h0010, 2'b00, 2'b00, 0);
        vecs[8]  = mk(2'b01, 2'b00, 2'b00, 16'h0030, 16'h0000, 1, 0, 32'h0, 0,
                      2'b01, 1, 16'h0020, 2'b00, 2'b00, 0);
        vecs[9]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 0, 32'h0, 0,
                      2'b00, 1, 16'h0030, 2'b00, 2'b00, 0);
        vecs[10] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 1, 32'h11111111, 0,
                      2'b00, 0, 16'h0030, 2'b10, 2'b00, 0);
        vecs[11] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 1, 32'h22222222, 0,
                      2'b00, 0, 16'h0030, 2'b01, 2'b00, 0);
        vecs[12] = mk(2'b11, 2'b01, 2'b01, 16'h0040, 16'h0050, 0, 0, 32'h0, 0,
                      2'b10, 0, 16'h0030, 2'b00, 2'b00, 0);
        vecs[13] = mk(2'b01, 2'b01, 2'b01, 16'h0040, 16'h0000, 1, 0, 32'h0, 0,
                      2'b01, 1, 16'h0050, 2'b00, 2'b00, 0);
        vecs[14] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 0, 32'h0, 0,
                      2'b00, 1, 16'h0040, 2'b00, 2'b00, 0);
        vecs[15] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 1, 32'h33333333, 1,
                      2'b00, 0, 16'h0040, 2'b10, 2'b01, 0);
        vecs[16] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 32'h0, 1,
                      2'b00, 0, 16'h0040, 2'b00, 2'b00, 0);
        vecs[17] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 32'h0, 0,
                      2'b00, 0, 16'h0040, 2'b00, 2'b00, 1);
        vecs[18] = vecs[17];

        // Reset state.
        clear_inputs();
        do_reset();
        @(negedge clk);
        check("reset state", {req_ready, csb_valid, csb_addr, csb_wdat, csb_write, csb_nposted,
                              rsp_rv, rsp_wc, err}, '0);
        next_cycle();

        // Round-robin between two continuous posted writers, no bubbles.
        do_reset();
        set_req(0, 1, 1, 0, 16'h0100, 32'hA0A0A0A0);
        set_req(1, 1, 1, 0, 16'h0200, 32'hB0B0B0B0);
        csb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rr grant %0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr valid %0d", k), csb_valid, (k != 0));
            if (k > 0) begin
                check($sformatf("rr addr %0d", k), csb_addr,
                      ((k - 1) % 2 == 0) ? 16'h0100 : 16'h0200);
            end
            next_cycle();
        end

        // Read FIFO full: fifth read waits, then wins in the same cycle as a response.
        do_reset();
        set_req(0, 1, 0, 0, 16'h0300, 32'h0);
        csb_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin
                csb_rv    = 1'b1;
                csb_rdata = 32'hAAAA5555;
            end
            @(negedge clk);
            check($sformatf("full grant %0d", k), req_ready, (k < 4 || k == 6) ? 2'b01 : 2'b00);
            if (k == 5) check("full bubble", csb_valid, 1'b0);
            if (k == 6) check("full pop route", {rsp_rv, rsp_rdata}, {2'b01, 32'hAAAA5555});
            next_cycle();
        end
        clear_inputs();

        // Directed vector table.
        do_reset();
        for (int v = 0; v < 19; v++) begin
            req_valid   = vecs[v].rv;
            req_write   = vecs[v].wr;
            req_nposted = vecs[v].np;
            req_addr    = {vecs[v].a1, vecs[v].a0};
            req_wdat    = {16'h0, vecs[v].a1, 16'h0, vecs[v].a0};
            csb_ready   = vecs[v].crdy;
            csb_rv      = vecs[v].crv;
            csb_rdata   = vecs[v].cdata;
            csb_wc      = vecs[v].cwc;
            @(negedge clk);
            check($sformatf("vector %0d", v),
                  {req_ready, csb_valid, csb_addr, rsp_rv, rsp_wc, rsp_rdata, err},
                  {vecs[v].e_rdy, vecs[v].e_cv, vecs[v].e_addr, vecs[v].e_rrv, vecs[v].e_rwc,
                   vecs[v].cdata, vecs[v].e_err});
            next_cycle();
        end
        clear_inputs();

        // Asynchronous reset while a request is issuing, then a stray response.
        set_req(0, 1, 0, 0, 16'h0060, 32'h0);
        @(negedge clk);
        check("pre-reset grant", req_ready, 2'b01);
        next_cycle();
        clear_inputs();
        #1;
        check("pre-reset issue", {csb_valid, err}, 2'b11);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset", {csb_valid, err, csb_addr}, '0);
        next_cycle();
        rst_n = 1'b1;
        csb_rv    = 1'b1;
        csb_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        check("stray read dropped", rsp_rv, 2'b00);
        next_cycle();
        csb_rv = 1'b0;
        check("stray read err", err, 1'b1);

        // Randomized traffic against the reference model.
        do_reset();
        run_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
